// File: rtl/wave_edge_gen_pkg.sv
// Shared types and helpers for the programmable waveform/edge generator.
// State encoding, default counter width and the zero-to-one count mapping.
package wave_edge_gen_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PHASE,
        S_HIGH,
        S_LOW
    } state_t;

    // A programmed count of 0 behaves as 1 so the waveform never stalls.
    function automatic logic [31:0] eff_cnt(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/wave_edge_gen_if.sv
// Control/status bundle of the waveform generator.
// Optional burst_len/done members exist when WAVE_EDGE_GEN_BURST_EN is defined.
interface wave_edge_gen_if
    import wave_edge_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic             wave_out;
    logic             rise_strb;
    logic             fall_strb;
    logic             busy;
`ifdef WAVE_EDGE_GEN_BURST_EN
    logic [CNT_W-1:0] burst_len;
    logic             done;

    modport master (
        output en, load, high_cnt, low_cnt, phase_cnt, burst_len,
        input  wave_out, rise_strb, fall_strb, busy, done
    );
    modport slave (
        input  en, load, high_cnt, low_cnt, phase_cnt, burst_len,
        output wave_out, rise_strb, fall_strb, busy, done
    );
`else
    modport master (
        output en, load, high_cnt, low_cnt, phase_cnt,
        input  wave_out, rise_strb, fall_strb, busy
    );
    modport slave (
        input  en, load, high_cnt, low_cnt, phase_cnt,
        output wave_out, rise_strb, fall_strb, busy
    );
`endif
endinterface

// File: rtl/wave_edge_gen_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Shared by the phase, high and low timing intervals.
module wave_edge_gen_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             dec,
    input  logic [CNT_W-1:0] val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wave_edge_gen.sv
// Programmable waveform/edge generator with registered wave and edge strobes.
// Burst mode (burst_len/done) is built when WAVE_EDGE_GEN_BURST_EN is defined.
module wave_edge_gen
    import wave_edge_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic           clk,
    input logic           rst,
    wave_edge_gen_if.slave bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    state_t state;
    cnt_t   sh_high;
    cnt_t   sh_low;
    cnt_t   sh_phase;
    cnt_t   act_high;
    cnt_t   act_low;
    logic   stop_req;

    cnt_t   new_high;
    cnt_t   new_low;
    cnt_t   new_phase;
    logic   cnt_ld;
    logic   cnt_dec;
    cnt_t   cnt_val;
    logic   cnt_zero;
    logic   start_ok;
    logic   burst_hit;

    function automatic cnt_t dec1(input cnt_t v);
        return cnt_t'(eff_cnt(32'(v)) - 32'd1);
    endfunction

    // A load on the same cycle as a boundary takes effect immediately.
    assign new_high  = bus.load ? bus.high_cnt  : sh_high;
    assign new_low   = bus.load ? bus.low_cnt   : sh_low;
    assign new_phase = bus.load ? bus.phase_cnt : sh_phase;

`ifdef WAVE_EDGE_GEN_BURST_EN
    cnt_t per_cnt;
    logic blk;
    assign start_ok  = bus.en && !blk;
    assign burst_hit = (bus.burst_len != '0) &&
                       (cnt_t'(per_cnt + 1'b1) == bus.burst_len);
`else
    assign start_ok  = bus.en;
    assign burst_hit = 1'b0;
`endif

    always_comb begin
        cnt_ld  = 1'b0;
        cnt_val = '0;
        cnt_dec = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    cnt_ld  = 1'b1;
                    cnt_val = (new_phase != '0) ?
                              cnt_t'(new_phase - 1'b1) : dec1(new_high);
                end
            end
            S_PHASE: begin
                cnt_ld  = cnt_zero;
                cnt_val = dec1(act_high);
            end
            S_HIGH: begin
                cnt_ld  = cnt_zero;
                cnt_val = dec1(act_low);
            end
            S_LOW: begin
                cnt_ld  = cnt_zero;
                cnt_val = dec1(new_high);
            end
        endcase
    end

    wave_edge_gen_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (cnt_ld),
        .dec  (cnt_dec),
        .val  (cnt_val),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.wave_out  <= 1'b0;
            bus.rise_strb <= 1'b0;
            bus.fall_strb <= 1'b0;
            bus.busy      <= 1'b0;
            sh_high       <= cnt_t'(1);
            sh_low        <= cnt_t'(1);
            sh_phase      <= '0;
            act_high      <= cnt_t'(1);
            act_low       <= cnt_t'(1);
            stop_req      <= 1'b0;
`ifdef WAVE_EDGE_GEN_BURST_EN
            per_cnt       <= '0;
            blk           <= 1'b0;
            bus.done      <= 1'b0;
`endif
        end else begin
            bus.rise_strb <= 1'b0;
            bus.fall_strb <= 1'b0;
`ifdef WAVE_EDGE_GEN_BURST_EN
            bus.done <= 1'b0;
            if (!bus.en) blk <= 1'b0;
`endif
            if (bus.load) begin
                sh_high  <= bus.high_cnt;
                sh_low   <= bus.low_cnt;
                sh_phase <= bus.phase_cnt;
            end
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        act_high <= new_high;
                        act_low  <= new_low;
                        stop_req <= 1'b0;
                        bus.busy <= 1'b1;
`ifdef WAVE_EDGE_GEN_BURST_EN
                        per_cnt  <= '0;
`endif
                        if (new_phase != '0) begin
                            state <= S_PHASE;
                        end else begin
                            state         <= S_HIGH;
                            bus.wave_out  <= 1'b1;
                            bus.rise_strb <= 1'b1;
                        end
                    end
                end
                S_PHASE: begin
                    if (!bus.en) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt_zero) begin
                        state         <= S_HIGH;
                        bus.wave_out  <= 1'b1;
                        bus.rise_strb <= 1'b1;
                    end
                end
                S_HIGH: begin
                    // A stop request mid-high is remembered so the pulse completes.
                    if (!bus.en) stop_req <= 1'b1;
                    if (cnt_zero) begin
                        bus.wave_out  <= 1'b0;
                        bus.fall_strb <= 1'b1;
                        if (!bus.en || stop_req) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (!bus.en) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt_zero) begin
`ifdef WAVE_EDGE_GEN_BURST_EN
                        per_cnt <= cnt_t'(per_cnt + 1'b1);
`endif
                        if (burst_hit) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
`ifdef WAVE_EDGE_GEN_BURST_EN
                            bus.done <= 1'b1;
                            blk      <= 1'b1;
`endif
                        end else begin
                            act_high      <= new_high;
                            act_low       <= new_low;
                            state         <= S_HIGH;
                            bus.wave_out  <= 1'b1;
                            bus.rise_strb <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
